// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths, PC increment, default reset PC, FSM state and FIFO entry layout.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop,
        StHold
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle around the fetch stage: imem request/response, redirect and Decode channel.
// master = fetch stage side, slave = memory/redirect/Decode side.
interface fetch_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries; Depth must be a power of two.
// Flush dominates push; push and pop together are legal even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
    localparam logic [PtrW:0]   CntFull = (PtrW+1)'(Depth);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        if (do_push && !do_pop) begin
            count_d = count_q + CntOne;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntOne;
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, word buffer and redirect handling.
// Optional FETCH_PERF_EN adds fetched-word and redirect counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned     CntW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] CntAlmostFull = CntW'(FIFO_DEPTH - 1);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            started_q;

    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    fetch_entry_t    fifo_wdata, fifo_rdata;
    logic            req_fire, rsp_space;

    // Request is held off for the first cycle out of reset.
    assign bus.imem_req_valid = started_q && (state_q == StReq);
    assign bus.imem_req_addr  = pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_rdata.instr;
    assign bus.instr_pc    = fifo_rdata.pc;
    assign fifo_pop        = !fifo_empty && bus.instr_ready;
    assign fifo_wdata      = '{pc: pc_q, instr: bus.imem_rsp_data};

    // Space left after this cycle's push and any concurrent pop.
    assign rsp_space = fifo_pop ? !fifo_full : (fifo_count < CntAlmostFull);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (bus.redirect_valid) begin
            fifo_flush = 1'b1;
            pc_d       = bus.redirect_pc;
            unique case (state_q)
                StReq:  state_d = req_fire ? StDrop : StReq;
                StWait: state_d = bus.imem_rsp_valid ? StReq : StDrop;
                StDrop: state_d = StDrop;
                StHold: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (req_fire) state_d = StWait;
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        fifo_push = 1'b1;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = rsp_space ? StReq : StHold;
                    end
                end
                StDrop: begin
                    if (bus.imem_rsp_valid) state_d = StReq;
                end
                StHold: begin
                    if (!fifo_full) state_d = StReq;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            started_q <= 1'b1;
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (fifo_push)          perf_fetch_q <= perf_fetch_q + 32'd1;
            if (bus.redirect_valid) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of Decode.
- Keeps the PC and issues one word request at a time to instruction memory over a valid/ready request channel with a variable-latency response.
- Buffers returned words in a small FIFO and presents {instr, instr_pc} to Decode with a valid/ready handshake.
- Handles redirects (branch/jump): flushes buffered words and discards any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req_valid  out  1  request address valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address (PC).
- imem_rsp_valid  in  1  response data valid; exactly one response per accepted request, no earlier than 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word; [31:25] opcode, [24:20] dst, [19:15] src1, [14:10] src2, [9:0] offsetlo.
- redirect_valid  in  1  redirect request, one cycle.
- redirect_pc  in  32  new fetch PC.
- instr_valid  out  1  instr/instr_pc valid to Decode.
- instr_ready  in  1  Decode accepts this cycle.
- instr  out  32  instruction word.
- instr_pc  out  32  address of instr.

Behaviour:
- **Reset** (rst_n low, async): state=REQ, pc=RESET_PC, FIFO empty.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - imem_req_valid may assert from the first clock edge after reset release.
- **FSM states**: REQ, WAIT, DROP, HOLD.
- **REQ**:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready: go to WAIT.
- **WAIT**: imem_req_valid=0. On imem_rsp_valid:
  - push {imem_rsp_data, pc} into the FIFO;
  - pc <= pc+4 (32-bit wrap: 32'hFFFF_FFFC+4 -> 0);
  - go to REQ if the FIFO has space after push/pop this cycle, else HOLD.
- **HOLD**:
  - imem_req_valid=0.
  - Go to REQ when the FIFO count drops below FIFO_DEPTH.
- **Issue rule**: a request is issued only when the FIFO is not full, so every response always finds space. No overflow path is needed.
- **DROP**:
  - Waits for the response of a cancelled request and discards it.
  - On imem_rsp_valid: go to REQ; no push, pc unchanged.
- **Redirect** (redirect_valid=1), with priority over all other events:
  - FIFO flushed; instr_valid=0 from the next cycle; pc <= redirect_pc.
  - Next state by current state:
    - REQ without handshake -> REQ.
    - REQ with handshake in the same cycle -> DROP.
    - WAIT with no response this cycle -> DROP.
    - WAIT with a response this cycle -> REQ (response discarded).
    - DROP -> DROP.
    - HOLD -> REQ.
- **Decode side**:
  - instr_valid = FIFO not empty; instr/instr_pc = FIFO head.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are legal at any count, including full.
  - instr/instr_pc hold their value while instr_valid & !instr_ready.
- **Latency**:
  - Response at cycle N -> instr_valid at N+1 when the FIFO was empty.
  - Best-case sustained throughput: 1 word per 2 cycles with 1-cycle memory latency (single outstanding request).
- **Mid-operation reset**: any state returns to reset values immediately. A memory response arriving after reset release with no request outstanding is ignored (state REQ).

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - adds output ports perf_fetch_cnt[31:0] (words pushed into the FIFO) and perf_flush_cnt[31:0] (redirects taken);
  - both reset to 0 and wrap at 2^32.
- When undefined:
  - ports and counters absent;
  - functional behaviour identical.

Decomposition:
- Package fetch_pkg:
  - state enum {REQ, WAIT, DROP, HOLD};
  - INSTR_W=32, PC_W=32, PC_STEP=32'd4;
  - default RESET_PC.
- Sub-module fetch_fifo:
  - synchronous FIFO, 64-bit entries {pc, instr}, DEPTH parameter;
  - push/pop/flush, full/empty/count;
  - flush dominates push.
- FSM and PC logic stay in fetch_stage.

Test Plan:
- **Reset release, always-ready memory (1-cycle latency), instr_ready=1**: requests at 0x0, 0x4, 0x8. Decode sees instr_pc 0x0, 0x4, 0x8 in order with matching data.
- **instr_ready=0 for 10 cycles**:
  - FIFO fills with 2 entries; state HOLD; imem_req_valid=0.
  - instr stays at pc 0x0.
  - When ready returns, fetching resumes at 0x8.
- **Redirect to 0x100 while in WAIT, response 3 cycles later**:
  - response discarded (DROP);
  - next request addr=0x100;
  - no word from the old PC reaches Decode.
- **Redirect coincident with request handshake, and coincident with rsp_valid**:
  - first case: exactly one response dropped, then request 0x100;
  - second case: response discarded, next request at 0x100 immediately.
- **Wrap-around and async reset**:
  - redirect_pc=32'hFFFF_FFFC: next fetch addr=0x0.
  - Asserting rst_n low mid-WAIT: instr_valid=0 and imem_req_valid=0 immediately.
  - After release, first request at RESET_PC.
- **With FETCH_PERF_EN**: after 5 fetched words and 2 redirects, perf_fetch_cnt=5 and perf_flush_cnt=2.
